// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   Fabric-side APB3 initiator. Converts a valid/ready command stream into
//   single APB3 read/write transfers, one outstanding at a time, and returns
//   exactly one response beat per transfer.
//
// Ports
//   PCLK, PRESET      : clock, synchronous active-high reset
//   cmd_*             : command stream (valid/ready, write, addr, wdata)
//   rsp_*             : response stream (valid/ready, rdata, err, timeout)
//   PSEL..PSLVERR     : APB3 initiator signals
//
// Build option
//   APB_MASTER_TIMEOUT_EN : when defined, an ACCESS phase that waits
//   TIMEOUT_CYCLES cycles with PREADY low is aborted and answered with
//   rsp_err=1, rsp_timeout=1. When undefined, ACCESS waits indefinitely and
//   rsp_timeout is tied low.

module apb_cmd_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      ST_ACCESS: begin
        // A ready slave takes priority over a timeout reached in the same cycle.
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_RESP;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == TO_LIMIT) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master: directed scenarios, a transaction-level
// model checked every cycle, and literal expectations for latency, wait-state
// counts and captured data.
module tb_apb_cmd_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_cmd_master #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transfer is "busy" from accept until the
  // response is consumed; m_cyc counts cycles since accept (1 = setup).
  bit            m_on = 1'b0;
  bit            m_busy, m_resp;
  int            m_cyc;
  logic          m_write, m_err, m_to;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always @(posedge PCLK) begin
    if (PRESET) begin
      m_on <= 1'b1; m_busy <= 1'b0; m_resp <= 1'b0; m_cyc <= 0;
      m_write <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_rdata <= '0; m_err <= 1'b0; m_to <= 1'b0;
    end else if (m_on) begin
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy  <= 1'b1;
          m_cyc   <= 1;
          m_write <= cmd_write;
          m_addr  <= cmd_addr;
          m_wdata <= cmd_write ? cmd_wdata : '0;
        end
      end else if (!m_resp) begin
        if (m_cyc >= 2 && PREADY) begin
          m_resp  <= 1'b1;
          m_rdata <= m_write ? '0 : PRDATA;
          m_err   <= PSLVERR;
          m_to    <= 1'b0;
        end else if (m_cyc >= 2 && TO_EN && (m_cyc - 2) == TO) begin
          m_resp  <= 1'b1;
          m_rdata <= '0;
          m_err   <= 1'b1;
          m_to    <= 1'b1;
        end else begin
          m_cyc <= m_cyc + 1;
        end
      end else if (rsp_ready) begin
        m_busy <= 1'b0;
        m_resp <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge PCLK) begin
    if (m_on) begin
      check("cmd_ready",   cmd_ready,   !m_busy);
      check("PSEL",        PSEL,        m_busy && !m_resp);
      check("PENABLE",     PENABLE,     m_busy && !m_resp && m_cyc >= 2);
      check("PWRITE",      PWRITE,      m_write);
      check("PADDR",       PADDR,       m_addr);
      check("PWDATA",      PWDATA,      m_wdata);
      check("rsp_valid",   rsp_valid,   m_resp);
      check("rsp_rdata",   rsp_rdata,   m_rdata);
      check("rsp_err",     rsp_err,     m_err);
      check("rsp_timeout", rsp_timeout, m_to);
    end
  end

  // Event statistics used by the literal expectations.
  int   tick = 0;
  int   acc_tick = 0, acc_cnt = 0, last_lat = -1, rsp_rise_cnt = 0;
  int   psel_rise_last = 0, psel_rise_prev = 0;
  int   pen_run = 0, last_pen_run = 0;
  logic psel_prev = 1'b0, rsp_prev = 1'b0;

  always @(posedge PCLK) tick <= tick + 1;

  always @(negedge PCLK) begin
    if (cmd_valid && cmd_ready) begin
      acc_tick = tick;
      acc_cnt++;
    end
    if (PSEL && !psel_prev) begin
      psel_rise_prev = psel_rise_last;
      psel_rise_last = tick;
    end
    if (rsp_valid && !rsp_prev) begin
      rsp_rise_cnt++;
      last_lat = tick - acc_tick;
    end
    if (PENABLE) pen_run++;
    else if (pen_run > 0) begin
      last_pen_run = pen_run;
      pen_run = 0;
    end
    psel_prev = PSEL;
    rsp_prev  = rsp_valid;
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int acc_before, rise_before;

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick_n(2);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_psel", PSEL, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    PRESET = 1'b0;
    tick_n(1);

    // Zero-wait write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4005_0000; cmd_wdata = 32'hDEAD_BEEF;
    PREADY = 1'b1; rsp_ready = 1'b1;
    tick_n(1);
    cmd_valid = 1'b0;
    check("wr_setup_psel", PSEL, 1);
    check("wr_setup_penable", PENABLE, 0);
    tick_n(1);
    check("wr_access_penable", PENABLE, 1);
    check("wr_access_pwdata", PWDATA, 32'hDEAD_BEEF);
    tick_n(1);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_err", rsp_err, 0);
    tick_n(1);
    check("wr_latency", last_lat, 3);

    // Read with three wait states; PSLVERR/PRDATA noise while not ready
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4005_0004; cmd_wdata = 32'hFFFF_0000;
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hBAD0_BAD0;
    tick_n(1);
    cmd_valid = 1'b0;
    check("rd_pwdata_zero", PWDATA, 0);
    tick_n(4);
    check("rd_wait_paddr", PADDR, 32'h4005_0004);
    check("rd_wait_penable", PENABLE, 1);
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h1234_5678;
    tick_n(1);
    check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("rd_rsp_err", rsp_err, 0);
    tick_n(1);
    check("rd_latency", last_lat, 6);
    check("rd_penable_cycles", last_pen_run, 4);

    // Slave error with response back-pressure
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4005_0008;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hA5A5_0001; rsp_ready = 1'b0;
    tick_n(1);
    cmd_valid = 1'b0;
    tick_n(2);
    PSLVERR = 1'b0; PRDATA = '0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4005_0010; cmd_wdata = 32'h0101_0101;
    for (int i = 0; i < 5; i++) begin
      check("err_hold_rsp_valid", rsp_valid, 1);
      check("err_hold_rsp_err", rsp_err, 1);
      check("err_hold_rsp_timeout", rsp_timeout, 0);
      check("err_hold_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      check("err_hold_cmd_ready", cmd_ready, 0);
      tick_n(1);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick_n(1);
    check("err_idle_cmd_ready", cmd_ready, 1);

    // Back-to-back commands with cmd_valid held
    acc_before = acc_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4005_0020; cmd_wdata = 32'h1111_1111;
    PREADY = 1'b1; rsp_ready = 1'b1;
    tick_n(1);
    cmd_write = 1'b0; cmd_addr = 32'h4005_0024; cmd_wdata = 32'h2222_2222; PRDATA = 32'h3333_3333;
    tick_n(4);
    cmd_valid = 1'b0;
    tick_n(1);
    check("b2b_psel_spacing", psel_rise_last - psel_rise_prev, 4);
    check("b2b_accepts", acc_cnt - acc_before, 2);
    tick_n(3);

    // Reset during ACCESS discards the transfer
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4005_0030; PREADY = 1'b0;
    tick_n(1);
    cmd_valid = 1'b0;
    tick_n(1);
    check("rst_mid_in_access", PENABLE, 1);
    rise_before = rsp_rise_cnt;
    PRESET = 1'b1;
    tick_n(1);
    check("rst_mid_psel", PSEL, 0);
    check("rst_mid_penable", PENABLE, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    PRESET = 1'b0; PREADY = 1'b1;
    tick_n(4);
    check("rst_mid_no_response", rsp_rise_cnt - rise_before, 0);

`ifdef APB_MASTER_TIMEOUT_EN
    // Slave never ready: abort after the limit
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4005_0040;
    PREADY = 1'b0; PRDATA = 32'h5555_AAAA; rsp_ready = 1'b1;
    tick_n(1);
    cmd_valid = 1'b0;
    tick_n(6);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_timeout", rsp_timeout, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    tick_n(1);
    check("to_penable_cycles", last_pen_run, 5);

    // PREADY on the limit cycle completes normally
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4005_0044;
    PREADY = 1'b0; PRDATA = 32'h0BAD_F00D;
    tick_n(1);
    cmd_valid = 1'b0;
    tick_n(5);
    PREADY = 1'b1;
    tick_n(1);
    check("to_edge_rsp_valid", rsp_valid, 1);
    check("to_edge_rsp_err", rsp_err, 0);
    check("to_edge_rsp_timeout", rsp_timeout, 0);
    check("to_edge_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    tick_n(1);
    check("to_edge_penable_cycles", last_pen_run, 5);
`else
    // Without the timeout, a long wait still completes normally
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4005_0040;
    PREADY = 1'b0; PRDATA = 32'h5555_AAAA; rsp_ready = 1'b1;
    tick_n(1);
    cmd_valid = 1'b0;
    tick_n(300);
    PREADY = 1'b1;
    tick_n(1);
    check("long_rsp_valid", rsp_valid, 1);
    check("long_rsp_err", rsp_err, 0);
    check("long_rsp_timeout", rsp_timeout, 0);
    check("long_rsp_rdata", rsp_rdata, 32'h5555_AAAA);
    tick_n(1);
    check("long_penable_cycles", last_pen_run, 300);
`endif

    tick_n(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
